bitserial_exec_ctrl: RTL and testbench

BITSERIAL_EXEC_CTRL -- requirements
Module: bitserial_exec_ctrl

---
 rtl/bitserial_exec_ctrl_if.sv | 18 +
 rtl/bitserial_exec_ctrl.sv | 159 +++++++++++++++
 tb/tb_bitserial_exec_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitserial_exec_ctrl_if.sv
// Instruction handshake between an issuing master and the bit-serial controller.
interface bitserial_exec_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/bitserial_exec_ctrl.sv
// Bit-serial execution controller: accepts one instruction at a time, decodes
// the opcode into ALU controls, sequences WIDTH LSB-first shift cycles gated by
// run_en, then issues a one-cycle write-back/completion pulse.
module bitserial_exec_ctrl #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitserial_exec_ctrl_if.slave bus,
    input  logic                 run_en,
    output logic                 load_en,
    output logic                 shift_en,
    output logic [2:0]           alu_op,
    output logic                 invert_b,
    output logic                 carry_init,
    output logic                 first_bit,
    output logic [IDX_W-1:0]     bit_idx,
    output logic                 wb_en,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [2:0]       alu_op_q;
    logic             invert_b_q;
    logic             carry_init_q;
    logic             first_bit_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic             load_en_q;
    logic             wb_en_q;
    logic             done_q;
    logic             illegal_q;

    logic             legal_d;
    logic [2:0]       alu_op_d;
    logic             invert_b_d;
    logic             carry_init_d;
    logic             op_legal;
    logic             last_bit;

    // Operand bits [11:0] belong to the datapath; the controller ignores them.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[11:0];

    // Opcode decode of the word presented on the bus, captured at acceptance.
    always_comb begin
        legal_d      = 1'b1;
        alu_op_d     = 3'd0;
        invert_b_d   = 1'b0;
        carry_init_d = 1'b0;
        case (bus.instr[15:12])
            4'd0: alu_op_d = 3'd0;
            4'd1: begin
                alu_op_d     = 3'd0;
                invert_b_d   = 1'b1;
                carry_init_d = 1'b1;
            end
            4'd2: alu_op_d = 3'd1;
            4'd3: alu_op_d = 3'd2;
            4'd4: alu_op_d = 3'd3;
            4'd5: alu_op_d = 3'd4;
            default: legal_d = 1'b0;
        endcase
    end

    assign op_legal = (op_q <= 4'd5);
    assign last_bit = (bit_idx_q == IDX_W'(WIDTH - 1));

    // Controller FSM; every strobe is registered on the transition into the
    // state that owns it so it is valid for that state's whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            alu_op_q     <= '0;
            invert_b_q   <= 1'b0;
            carry_init_q <= 1'b0;
            first_bit_q  <= 1'b0;
            bit_idx_q    <= '0;
            load_en_q    <= 1'b0;
            wb_en_q      <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        state_q      <= DECODE;
                        op_q         <= bus.instr[15:12];
                        alu_op_q     <= alu_op_d;
                        invert_b_q   <= invert_b_d;
                        carry_init_q <= carry_init_d;
                        bit_idx_q    <= '0;
                        first_bit_q  <= 1'b0;
                        load_en_q    <= legal_d;
                        // An unsupported opcode completes immediately in DECODE.
                        illegal_q    <= ~legal_d;
                        done_q       <= ~legal_d;
                    end
                end
                DECODE: begin
                    load_en_q <= 1'b0;
                    illegal_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (op_legal) begin
                        state_q     <= EXEC;
                        first_bit_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    if (run_en) begin
                        first_bit_q <= 1'b0;
                        // bit_idx stops at WIDTH-1 rather than wrapping.
                        if (last_bit) begin
                            state_q <= WB;
                            wb_en_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                WB: begin
                    wb_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign shift_en        = (state_q == EXEC) && run_en;

    assign load_en    = load_en_q;
    assign alu_op     = alu_op_q;
    assign invert_b   = invert_b_q;
    assign carry_init = carry_init_q;
    assign first_bit  = first_bit_q;
    assign bit_idx    = bit_idx_q;
    assign wb_en      = wb_en_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_bitserial_exec_ctrl.sv
// Directed bench for bitserial_exec_ctrl with WIDTH=16 and hand-derived timing.
module tb_bitserial_exec_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run_en;
    logic       load_en, shift_en, invert_b, carry_init, first_bit;
    logic       wb_en, busy, done, illegal;
    logic [2:0] alu_op;
    logic [3:0] bit_idx;
    logic [4:0] strobes;

    int errors = 0;
    int checks = 0;

    bitserial_exec_ctrl_if bus();

    bitserial_exec_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .run_en     (run_en),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .alu_op     (alu_op),
        .invert_b   (invert_b),
        .carry_init (carry_init),
        .first_bit  (first_bit),
        .bit_idx    (bit_idx),
        .wb_en      (wb_en),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    assign strobes = {load_en, shift_en, wb_en, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run_en = 1'b0;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b0;
        #12;
        checks++;
        if (strobes !== 5'b00000) begin errors++; $display("FAIL reset_strobes: got %b want 00000", strobes); end
        checks++;
        if ({busy, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL reset_busy_ready: got %b want 01", {busy, bus.instr_ready}); end
        checks++;
        if ({alu_op, invert_b, carry_init, first_bit, bit_idx} !== 10'd0) begin
            errors++;
            $display("FAIL reset_regs: got alu=%0d inv=%b cin=%b fb=%b idx=%0d want all 0", alu_op, invert_b, carry_init, first_bit, bit_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL reset_release: got %b want 01", {busy, bus.instr_ready}); end
    endtask

    task automatic test_add();
        run_en = 1'b1;
        bus.instr = 16'h0123;
        bus.instr_valid = 1'b1;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", bus.instr_ready); end
        step();
        bus.instr_valid = 1'b0;
        checks++;
        if ({strobes, busy, bit_idx, alu_op, invert_b, carry_init} !== {5'b10000, 1'b1, 4'd0, 3'd0, 2'b00}) begin
            errors++;
            $display("FAIL add_decode: got str=%b busy=%b idx=%0d alu=%0d inv=%b cin=%b want str=10000 busy=1 idx=0 alu=0 inv=0 cin=0",
                     strobes, busy, bit_idx, alu_op, invert_b, carry_init);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if ({strobes, bit_idx, first_bit} !== {5'b01000, 4'(k), (k == 0)}) begin
                errors++;
                $display("FAIL add_shift%0d: got str=%b idx=%0d fb=%b want str=01000 idx=%0d fb=%b",
                         k, strobes, bit_idx, first_bit, k, (k == 0));
            end
        end
        step();
        checks++;
        if ({strobes, bit_idx, busy} !== {5'b00110, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL add_wb: got str=%b idx=%0d busy=%b want str=00110 idx=15 busy=1", strobes, bit_idx, busy);
        end
        step();
        checks++;
        if ({strobes, bus.instr_ready, busy} !== 7'b0000010) begin
            errors++;
            $display("FAIL add_idle: got str=%b rdy=%b busy=%b want str=00000 rdy=1 busy=0", strobes, bus.instr_ready, busy);
        end
    endtask

    task automatic test_sub();
        run_en = 1'b1;
        bus.instr = 16'h1ABC;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if ({alu_op, invert_b, carry_init} !== 5'b000_1_1) begin
                errors++;
                $display("FAIL sub_ctrl_c%0d: got alu=%0d inv=%b cin=%b want alu=0 inv=1 cin=1", c, alu_op, invert_b, carry_init);
            end
            if (c == 18) begin
                checks++;
                if (strobes !== 5'b00110) begin errors++; $display("FAIL sub_wb: got %b want 00110", strobes); end
            end
            step();
        end
    endtask

    task automatic test_decode_map();
        for (int op = 2; op <= 5; op++) begin
            int n;
            logic [3:0] opv;
            opv = 4'(op);
            run_en = 1'b1;
            bus.instr = {opv, 12'h5A5};
            bus.instr_valid = 1'b1;
            step();
            bus.instr_valid = 1'b0;
            checks++;
            if ({load_en, alu_op, invert_b, carry_init} !== {1'b1, 3'(op - 1), 2'b00}) begin
                errors++;
                $display("FAIL map_op%0d: got ld=%b alu=%0d inv=%b cin=%b want ld=1 alu=%0d inv=0 cin=0",
                         op, load_en, alu_op, invert_b, carry_init, op - 1);
            end
            n = 0;
            while (done !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            checks++;
            if (n !== 17) begin errors++; $display("FAIL map_lat_op%0d: got %0d cycles after decode want 17", op, n); end
            step();
        end
    endtask

    task automatic test_illegal();
        logic [15:0] vec [2] = '{16'h6000, 16'hF000};
        for (int i = 0; i < 2; i++) begin
            run_en = 1'b1;
            bus.instr = vec[i];
            bus.instr_valid = 1'b1;
            step();
            bus.instr_valid = 1'b0;
            checks++;
            if ({strobes, busy} !== 6'b00011_1) begin
                errors++;
                $display("FAIL illegal_decode_%h: got str=%b busy=%b want str=00011 busy=1", vec[i], strobes, busy);
            end
            step();
            checks++;
            if ({strobes, bus.instr_ready} !== 6'b00000_1) begin
                errors++;
                $display("FAIL illegal_after_%h: got str=%b rdy=%b want str=00000 rdy=1", vec[i], strobes, bus.instr_ready);
            end
        end
    endtask

    task automatic test_stall();
        int exp_idx;
        int nshift;
        logic run;
        run_en = 1'b1;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        exp_idx = 0;
        nshift = 0;
        for (int c = 2; c <= 22; c++) begin
            run = !(c >= 9 && c <= 13);
            run_en = run;
            #1;
            checks++;
            if ({shift_en, bit_idx} !== {run, 4'(exp_idx)}) begin
                errors++;
                $display("FAIL stall_c%0d: got sh=%b idx=%0d want sh=%b idx=%0d", c, shift_en, bit_idx, run, exp_idx);
            end
            if (shift_en === 1'b1) nshift++;
            if (run && exp_idx < 15) exp_idx++;
            step();
        end
        run_en = 1'b1;
        checks++;
        if ({strobes, bit_idx} !== {5'b00110, 4'd15}) begin
            errors++;
            $display("FAIL stall_wb_t23: got str=%b idx=%0d want str=00110 idx=15", strobes, bit_idx);
        end
        checks++;
        if (nshift !== 16) begin errors++; $display("FAIL stall_shift_count: got %0d want 16", nshift); end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        run_en = 1'b1;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (bit_idx !== 4'd9) begin errors++; $display("FAIL rstmid_pre_idx: got %0d want 9", bit_idx); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({strobes, busy, bus.instr_ready, bit_idx, alu_op, invert_b, carry_init, first_bit} !== {5'b00000, 2'b01, 10'd0}) begin
            errors++;
            $display("FAIL rstmid_async: got str=%b busy=%b rdy=%b idx=%0d alu=%0d inv=%b cin=%b fb=%b want all reset values",
                     strobes, busy, bus.instr_ready, bit_idx, alu_op, invert_b, carry_init, first_bit);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (strobes !== 5'b00000) begin errors++; $display("FAIL rstmid_hold%0d: got %b want 00000", k, strobes); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_release: got %b want 01", {busy, bus.instr_ready}); end
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        checks++;
        if (load_en !== 1'b1) begin errors++; $display("FAIL rstmid_new_load: got %b want 1", load_en); end
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if ({n, wb_en} !== {32'd17, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_new_done: got %0d cycles wb=%b want 17 wb=1", n, wb_en);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int accepts;
        int dones;
        int acc_cyc [2];
        acc_cyc = '{-1, -1};
        run_en = 1'b1;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b1;
        cyc = 0;
        accepts = 0;
        dones = 0;
        while (cyc < 50) begin
            if (done === 1'b1) dones++;
            if (accepts == 1 && busy === 1'b1) begin
                checks++;
                if (alu_op !== 3'd0) begin errors++; $display("FAIL b2b_hold_c%0d: got alu=%0d want 0", cyc, alu_op); end
            end
            if (bus.instr_ready === 1'b1 && bus.instr_valid === 1'b1) begin
                if (accepts < 2) acc_cyc[accepts] = cyc;
                accepts++;
            end
            step();
            cyc++;
            if (accepts == 1) bus.instr = 16'h2000;
            if (accepts >= 2) bus.instr_valid = 1'b0;
        end
        checks++;
        if (accepts !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
        checks++;
        if (acc_cyc[1] !== 19) begin errors++; $display("FAIL b2b_second_accept: got cycle %0d want 19", acc_cyc[1]); end
        checks++;
        if (dones !== 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", dones); end
        checks++;
        if (alu_op !== 3'd1) begin errors++; $display("FAIL b2b_second_op: got alu=%0d want 1", alu_op); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_decode_map();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
